// File: rtl/hdlverifier_playback_data_pkg.sv
// Shared definitions for the stimulus playback engine.
package hdlverifier_playback_data_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPlay  = 2'd2,
    StDone  = 2'd3
  } play_state_e;

endpackage

// File: rtl/hdlverifier_dcram.sv
// Simple dual-clock RAM: one write port, one registered read port.
module hdlverifier_dcram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  wclk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rclk,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge wclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge rclk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hdlverifier_gray_cdc.sv
// Carries a slowly changing binary count across clock domains via gray code.
module hdlverifier_gray_cdc #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             src_clk,
  input  logic             dst_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_bin,
  output logic [WIDTH-1:0] dst_bin
);

  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_sync;
  logic [WIDTH-1:0] bin;

  // Registered so only one bit toggles per increment at the crossing.
  always_ff @(posedge src_clk or posedge reset) begin
    if (reset) gray_q <= '0;
    else       gray_q <= src_bin ^ (src_bin >> 1);
  end

  hdlverifier_synchronizer #(
    .WIDTH  (WIDTH),
    .STAGES (2)
  ) u_sync (
    .clk   (dst_clk),
    .reset (reset),
    .d     (gray_q),
    .q     (gray_sync)
  );

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) bin[i] = ^(gray_sync >> i);
  end

  always_ff @(posedge dst_clk or posedge reset) begin
    if (reset) dst_bin <= '0;
    else       dst_bin <= bin;
  end

endmodule

// File: rtl/hdlverifier_synchronizer.sv
// Multi-stage flop synchronizer into the destination clock domain.
module hdlverifier_synchronizer #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/hdlverifier_playback_data.sv
// Stimulus playback: host fills a RAM over JTAG, samples stream out in the design clock domain.
module hdlverifier_playback_data
  import hdlverifier_playback_data_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic                  start,
  input  logic                  immediate,
  input  logic                  run,
  input  logic                  loop_mode,
  input  logic [ADDR_WIDTH:0]   num_samples,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  input  logic                  tck,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  flag_done,
  output logic                  has_clk,
  output logic [ADDR_WIDTH-1:0] pass_count
);

  localparam int unsigned Depth = 2**ADDR_WIDTH;

  play_state_e           state_q, state_d;
  logic                  run_d1_q;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [ADDR_WIDTH-1:0] pass_q, pass_d;
  logic                  rd, rd_q;
  logic                  done_q, has_clk_q;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  run_rise;

  assign run_rise = run & ~run_d1_q;
  assign busy     = (state_q == StPlay);

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    pass_d  = pass_q;
    rd      = 1'b0;
    if (!run) begin
      state_d = StIdle;
      raddr_d = '0;
    end else begin
      unique case (state_q)
        StIdle:  if (run_rise) state_d = StArmed;
        StArmed: begin
          if (clk_enable && (start || immediate)) begin
            state_d = StPlay;
            raddr_d = '0;
          end
        end
        StPlay: begin
          if (clk_enable) begin
            rd = 1'b1;
            if (raddr_q == last_q) begin
              pass_d  = pass_q + 1'b1;
              raddr_d = '0;
              if (!loop_mode) state_d = StDone;
            end else begin
              raddr_d = raddr_q + 1'b1;
            end
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      run_d1_q  <= 1'b0;
      raddr_q   <= '0;
      last_q    <= '0;
      pass_q    <= '0;
      done_q    <= 1'b0;
      has_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_d1_q  <= run;
      raddr_q   <= raddr_d;
      pass_q    <= pass_d;
      done_q    <= (state_d == StDone);
      has_clk_q <= 1'b1;
      // Zero means a full RAM pass; the cast wraps DEPTH onto the top address.
      if (run_rise) begin
        last_q <= (num_samples == '0) ? ADDR_WIDTH'(Depth - 1)
                                      : ADDR_WIDTH'(num_samples - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else if (!run) begin
      rd_q       <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      rd_q       <= rd;
      data_valid <= rd_q;
      if (rd_q) data_out <= ram_rdata;
    end
  end

  hdlverifier_dcram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .wclk  (tck),
    .we    (wr),
    .waddr (waddr),
    .wdata (wdata),
    .rclk  (clk),
    .re    (rd),
    .raddr (raddr_q),
    .rdata (ram_rdata)
  );

  hdlverifier_synchronizer #(
    .WIDTH  (2),
    .STAGES (2)
  ) u_flag_sync (
    .clk   (tck),
    .reset (reset),
    .d     ({done_q, has_clk_q}),
    .q     ({flag_done, has_clk})
  );

  hdlverifier_gray_cdc #(
    .WIDTH (ADDR_WIDTH)
  ) u_pass_cdc (
    .src_clk (clk),
    .dst_clk (tck),
    .reset   (reset),
    .src_bin (pass_q),
    .dst_bin (pass_count)
  );

endmodule

// File: tb/tb_hdlverifier_playback_data.sv
// Bench for hdlverifier_playback_data: table scenarios, random scenarios, abort and reset cases.
module tb_hdlverifier_playback_data;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          tck = 1'b0;
  logic          reset = 1'b0;
  logic          clk_enable, start, immediate, run, loop_mode;
  logic [AW:0]   num_samples;
  logic [DW-1:0] data_out;
  logic          data_valid, busy;
  logic          wr;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          flag_done, has_clk;
  logic [AW-1:0] pass_count;

  always #5 clk = ~clk;
  always #7 tck = ~tck;

  hdlverifier_playback_data #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .start       (start),
    .immediate   (immediate),
    .run         (run),
    .loop_mode   (loop_mode),
    .num_samples (num_samples),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .tck         (tck),
    .wr          (wr),
    .waddr       (waddr),
    .wdata       (wdata),
    .flag_done   (flag_done),
    .has_clk     (has_clk),
    .pass_count  (pass_count)
  );

  typedef struct {
    int num;
    bit lp;
    int rds;
    int dens;
    bit imm;
    int exp_samples;
    int exp_passes;
  } vec_t;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [DW-1:0] ram_model [DEPTH];
  logic [DW-1:0] got_q [$];
  int            got_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && data_valid) begin
      got_q.push_back(data_out);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_write(input int a, input logic [DW-1:0] d);
    @(negedge tck);
    wr = 1'b1; waddr = AW'(a); wdata = d;
    @(negedge tck);
    wr = 1'b0;
    ram_model[a] = d;
  endtask

  task automatic load_pattern();
    for (int i = 0; i < DEPTH; i++) host_write(i, DW'(8'h10 + i));
  endtask

  task automatic load_random();
    for (int i = 0; i < DEPTH; i++) host_write(i, DW'($urandom_range(255)));
  endtask

  task automatic do_reset();
    run = 1'b0; start = 1'b0; immediate = 1'b0; clk_enable = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    got_q.delete();
    got_cyc.delete();
  endtask

  // Start strobe coincides with run rise (must be ignored), then a real start.
  task automatic arm_and_start(input bit use_imm);
    @(negedge clk);
    run = 1'b1; start = 1'b1; clk_enable = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("armed_not_busy", busy, 0);
    if (use_imm) immediate = 1'b1;
    else         start = 1'b1;
    @(negedge clk);
    start = 1'b0; immediate = 1'b0; clk_enable = 1'b0;
    chk("play_entered", busy, 1);
  endtask

  task automatic run_scen(input vec_t v);
    int  n_eff, rd_cnt, first_rd;
    bit  ok, ce;
    n_eff = (v.num == 0) ? DEPTH : v.num;
    do_reset();
    loop_mode   = v.lp;
    num_samples = (AW+1)'(v.num);
    arm_and_start(v.imm);
    rd_cnt = 0; first_rd = -1; ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (v.lp ? (rd_cnt == v.rds) : !busy) begin
        ok = 1'b1;
        break;
      end
      ce = ($urandom_range(99) < v.dens);
      clk_enable = ce;
      if (busy && ce) begin
        if (rd_cnt == 0) first_rd = cyc;
        rd_cnt++;
      end
    end
    clk_enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("play_done", ok, 1);
    chk("rd_count", rd_cnt, v.exp_samples);
    chk("sample_count", got_q.size(), v.exp_samples);
    for (int i = 0; i < got_q.size(); i++)
      chk($sformatf("sample%0d", i), got_q[i], ram_model[i % n_eff]);
    if (got_cyc.size() > 0) chk("latency", got_cyc[0] - first_rd, 2);
    repeat (6) @(posedge tck);
    #1;
    chk("pass_count", pass_count, v.exp_passes);
    chk("flag_done", flag_done, !v.lp);
    chk("busy_end", busy, v.lp);
    if (!v.lp) begin
      @(negedge clk);
      start = 1'b1; clk_enable = 1'b1;
      @(negedge clk);
      start = 1'b0; clk_enable = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored", busy, 0);
    end
    @(negedge clk);
    run = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    int   cnt, sz;
    vec_t rv;

    vecs[0] = '{8,  0, 8,  100, 0, 8,  1};
    vecs[1] = '{8,  1, 20, 100, 0, 20, 2};
    vecs[2] = '{8,  0, 8,  50,  1, 8,  1};
    vecs[3] = '{0,  0, 32, 100, 0, 32, 1};
    vecs[4] = '{1,  1, 5,  70,  1, 5,  5};
    vecs[5] = '{32, 1, 40, 80,  0, 40, 1};
    vecs[6] = '{5,  1, 23, 60,  0, 23, 4};

    run = 1'b0; start = 1'b0; immediate = 1'b0; clk_enable = 1'b0;
    loop_mode = 1'b0; num_samples = '0; wr = 1'b0; waddr = '0; wdata = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flag_done", flag_done, 0);
    chk("rst_has_clk", has_clk, 0);
    chk("rst_pass_count", pass_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    repeat (4) @(posedge tck);
    #1;
    chk("has_clk_after_reset", has_clk, 1);

    load_pattern();
    foreach (vecs[i]) run_scen(vecs[i]);

    // Abort mid-pass after three reads, then re-arm.
    do_reset();
    loop_mode = 1'b0; num_samples = 7'd8;
    arm_and_start(1'b0);
    cnt = 0;
    for (int k = 0; k < 100 && cnt < 3; k++) begin
      @(negedge clk);
      clk_enable = 1'b1;
      if (busy) cnt++;
    end
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", data_valid, 0);
    sz = got_q.size();
    repeat (3) @(negedge clk);
    chk("abort_no_late_samples", got_q.size(), sz);
    clk_enable = 1'b0;
    got_q.delete();
    got_cyc.delete();
    arm_and_start(1'b1);
    clk_enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("rearm_has_sample", got_q.size() > 0, 1);
    if (got_q.size() > 0) chk("rearm_first", got_q[0], ram_model[0]);
    clk_enable = 1'b0;
    run = 1'b0;

    // Asynchronous reset in the middle of a looping pass.
    do_reset();
    loop_mode = 1'b1; num_samples = 7'd2;
    arm_and_start(1'b0);
    clk_enable = 1'b1;
    repeat (8) @(negedge clk);
    repeat (6) @(posedge tck);
    #1;
    chk("pass_before_reset", pass_count != 0, 1);
    chk("valid_seen_before_reset", got_q.size() > 0, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_valid", data_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_has_clk", has_clk, 0);
    chk("mid_rst_flag_done", flag_done, 0);
    chk("mid_rst_pass_count", pass_count, 0);
    @(negedge clk);
    run = 1'b0; clk_enable = 1'b0;
    reset = 1'b0;

    for (int r = 0; r < 5; r++) begin
      load_random();
      rv.num  = $urandom_range(32);
      rv.lp   = $urandom_range(1);
      rv.dens = $urandom_range(100, 30);
      rv.imm  = $urandom_range(1);
      if (rv.lp) begin
        rv.rds         = $urandom_range(70, 1);
        rv.exp_samples = rv.rds;
        rv.exp_passes  = (rv.rds / ((rv.num == 0) ? DEPTH : rv.num)) % DEPTH;
      end else begin
        rv.rds         = (rv.num == 0) ? DEPTH : rv.num;
        rv.exp_samples = rv.rds;
        rv.exp_passes  = 1;
      end
      run_scen(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
